// File: rtl/ram2com_pkg.sv
// Frame layout and FSM state encodings shared by the ram2com reader
// and the ADC-to-RAM packer.
package ram2com_pkg;

  localparam int unsigned DATA_LEN = 64;
  localparam int unsigned CHIP_LEN = 8;
  localparam logic [7:0]  HEAD0    = 8'h55;
  localparam logic [7:0]  HEAD1    = 8'hAA;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WAIT,
    S_INIT,
    S_HEAD,
    S_READ,
    S_LOAD,
    S_SEND,
    S_SUM,
    S_DONE
  } state_t;

endpackage

// File: rtl/ram2com.sv
// Streams one frame from the sample RAM to the link transmitter:
// two header bytes, DATA_LEN*CHIP_LEN payload bytes, then an 8-bit additive checksum.
module ram2com
  import ram2com_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fs,
  output logic              fd,
  input  logic [ADDR_W-1:0] ram_rxa_init,
  output logic              ram_rxen,
  output logic [ADDR_W-1:0] ram_rxa,
  input  logic [7:0]        ram_rxd,
  output logic [7:0]        com_txd,
  output logic              com_txen,
  input  logic              com_ready
);

  localparam logic [9:0] LAST_BYTE = 10'(DATA_LEN * CHIP_LEN - 1);

  state_t     state;
  logic [9:0] byte_num;
  logic       head_num;
  logic [7:0] sum;

  assign ram_rxen = (state == S_READ);
  assign com_txen = (state == S_HEAD) || (state == S_SEND) || (state == S_SUM);
  assign fd       = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      ram_rxa  <= '0;
      com_txd  <= '0;
      byte_num <= '0;
      head_num <= 1'b0;
      sum      <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_WAIT;
        S_WAIT: if (fs) state <= S_INIT;
        S_INIT: begin
          ram_rxa  <= ram_rxa_init;
          byte_num <= '0;
          head_num <= 1'b0;
          sum      <= '0;
          com_txd  <= HEAD0;
          state    <= S_HEAD;
        end
        S_HEAD: if (com_ready) begin
          if (!head_num) begin
            com_txd  <= HEAD1;
            head_num <= 1'b1;
          end else begin
            state <= S_READ;
          end
        end
        S_READ: state <= S_LOAD;
        S_LOAD: begin
          com_txd <= ram_rxd;
          sum     <= sum + ram_rxd;
          state   <= S_SEND;
        end
        // Address advances only on accept, so a stalled byte is never re-read.
        S_SEND: if (com_ready) begin
          ram_rxa  <= ram_rxa + ADDR_W'(1);
          byte_num <= byte_num + 10'd1;
          if (byte_num == LAST_BYTE) begin
            com_txd <= sum;
            state   <= S_SUM;
          end else begin
            state <= S_READ;
          end
        end
        S_SUM:  if (com_ready) state <= S_DONE;
        S_DONE: if (!fs) state <= S_WAIT;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram2com.sv
// Self-checking bench for ram2com: random and patterned RAM contents,
// random link back-pressure, frame re-trigger and mid-frame reset.
module tb_ram2com;

  logic        clk = 1'b0;
  logic        rst;
  logic        fs;
  logic        fd;
  logic [11:0] ram_rxa_init;
  logic        ram_rxen;
  logic [11:0] ram_rxa;
  logic [7:0]  ram_rxd;
  logic [7:0]  com_txd;
  logic        com_txen;
  logic        com_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [4096];
  logic [7:0] rx[$];
  logic [7:0] expq[$];
  bit         rdy_rand = 1'b0;
  logic       stall    = 1'b0;
  logic [7:0] held     = 8'h00;

  always #5 clk = ~clk;

  ram2com #(.ADDR_W(12)) dut (
    .clk          (clk),
    .rst          (rst),
    .fs           (fs),
    .fd           (fd),
    .ram_rxa_init (ram_rxa_init),
    .ram_rxen     (ram_rxen),
    .ram_rxa      (ram_rxa),
    .ram_rxd      (ram_rxd),
    .com_txd      (com_txd),
    .com_txen     (com_txen),
    .com_ready    (com_ready)
  );

  // Synchronous RAM: data appears one cycle after the read enable.
  always @(posedge clk) if (ram_rxen) ram_rxd <= mem[ram_rxa];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Link side: drive ready for the coming edge, then log what that edge accepts.
  initial begin
    com_ready = 1'b1;
    forever begin
      @(negedge clk);
      com_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall && com_txen) check("stall_hold", com_txd, held);
      if (com_txen && com_ready && rst) rx.push_back(com_txd);
      stall = com_txen && !com_ready;
      held  = com_txd;
    end
  end

  task automatic build_expected(input logic [11:0] base);
    logic [7:0] s;
    s = 8'h00;
    expq.delete();
    expq.push_back(8'h55);
    expq.push_back(8'hAA);
    for (int i = 0; i < 512; i++) begin
      expq.push_back(mem[(int'(base) + i) % 4096]);
      s = s + mem[(int'(base) + i) % 4096];
    end
    expq.push_back(s);
  endtask

  task automatic run_frame(input logic [11:0] base, input bit hold, input bit timed, input string tag);
    int n;
    bit seen;
    build_expected(base);
    ram_rxa_init = base;
    @(negedge clk);
    rx.delete();
    fs = 1'b1;
    @(posedge clk);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20000) begin
      @(negedge clk);
      if (!hold) fs = 1'b0;
      if (fd) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
    if (timed) check({tag, "_fd_edge"}, n, 1540);
    check({tag, "_len"}, rx.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rx.size(); i++) begin
      int f;
      f = n_fail;
      check($sformatf("%s_byte%0d", tag, i), rx[i], expq[i]);
      if (n_fail != f) break;
    end
    check({tag, "_rxa_end"}, ram_rxa, 32'((int'(base) + 512) % 4096));
    if (hold) begin
      repeat (50) @(negedge clk);
      check({tag, "_fd_held"}, fd, 1'b1);
      check({tag, "_no_restart"}, rx.size(), expq.size());
      fs = 1'b0;
    end
  endtask

  initial begin
    int k;
    rst = 1'b0;
    fs = 1'b0;
    ram_rxa_init = 12'h000;
    for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    check("rst_ram_rxen", ram_rxen, 1'b0);
    check("rst_com_txen", com_txen, 1'b0);
    check("rst_fd", fd, 1'b0);
    check("rst_com_txd", com_txd, 8'h00);
    check("rst_ram_rxa", ram_rxa, 12'h000);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    run_frame(12'h000, 1'b0, 1'b1, "ramp0");
    run_frame(12'hF00, 1'b0, 1'b1, "rampF00");
    rdy_rand = 1'b1;
    run_frame(12'h000, 1'b0, 1'b0, "ramp_stall");
    rdy_rand = 1'b0;

    for (int i = 0; i < 4096; i++) mem[i] = 8'h01;
    run_frame(12'h000, 1'b0, 1'b1, "ones");
    for (int i = 0; i < 4096; i++) mem[i] = 8'h03;
    run_frame(12'h000, 1'b0, 1'b1, "threes");
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[0] = 8'h07;
    run_frame(12'h000, 1'b0, 1'b1, "single7");

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    rdy_rand = 1'b1;
    run_frame(12'($urandom), 1'b0, 1'b0, "rand_a");
    run_frame(12'($urandom), 1'b1, 1'b0, "hold");
    run_frame(12'($urandom), 1'b0, 1'b0, "retrig");
    rdy_rand = 1'b0;

    // Abandon a frame at payload byte 100.
    ram_rxa_init = 12'h123;
    @(negedge clk);
    rx.delete();
    fs = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fs = 1'b0;
    k = 0;
    while (rx.size() < 102 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("midrst_reached", 32'(rx.size() >= 102), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_ram_rxen", ram_rxen, 1'b0);
    check("midrst_com_txen", com_txen, 1'b0);
    check("midrst_fd", fd, 1'b0);
    check("midrst_com_txd", com_txd, 8'h00);
    check("midrst_ram_rxa", ram_rxa, 12'h000);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_idle_txen", com_txen, 1'b0);
    run_frame(12'h040, 1'b0, 1'b1, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
